// File: rtl/xbar_output_merge_8_1_seq.sv
// Per-output-port merge stage of the 8x8 crossbar: eight one-entry lane hold
// registers drained round-robin into a single registered valid/ready output.
module xbar_output_merge_8_1_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_INPUT_DATA  = 8,
  parameter int NUM_OUTPUT_DATA = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_DATA-1:0]             i_valid,
  input  logic [DATA_WIDTH*NUM_INPUT_DATA-1:0]  i_data_bus,
  input  logic                                  i_en,
  input  logic                                  i_ready,
  input  logic                                  i_clear_overflow,
  output logic                                  o_valid,
  output logic [DATA_WIDTH*NUM_OUTPUT_DATA-1:0] o_data_bus,
  output logic [$clog2(NUM_INPUT_DATA)-1:0]     o_src_id,
  output logic [NUM_INPUT_DATA-1:0]             o_overflow
);

  localparam int IDX_W = $clog2(NUM_INPUT_DATA);

  logic [NUM_INPUT_DATA-1:0] hold_valid_r;
  logic [DATA_WIDTH-1:0]     hold_data_r [NUM_INPUT_DATA];
  logic [IDX_W-1:0]          rr_ptr_r;

  logic                      load_s;
  logic                      grant_found_s;
  logic [IDX_W-1:0]          grant_idx_s;
  logic [NUM_INPUT_DATA-1:0] drain_s;
  logic [NUM_INPUT_DATA-1:0] capture_s;
  logic [NUM_INPUT_DATA-1:0] ovf_s;

  assign load_s = !o_valid || i_ready;

  // Circular first-set search over registered hold_valid starting at rr_ptr.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_INPUT_DATA; i++) begin
      if (!grant_found_s && hold_valid_r[rr_ptr_r + IDX_W'(i)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_ptr_r + IDX_W'(i);
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Per-lane drain, capture and drop decisions; a drained lane may refill in the same cycle.
  always_comb begin
    drain_s   = {NUM_INPUT_DATA{1'b0}};
    capture_s = {NUM_INPUT_DATA{1'b0}};
    ovf_s     = {NUM_INPUT_DATA{1'b0}};
    for (int k = 0; k < NUM_INPUT_DATA; k++) begin
      drain_s[k]   = load_s && grant_found_s && (grant_idx_s == IDX_W'(k));
      capture_s[k] = i_en && i_valid[k] && (!hold_valid_r[k] || drain_s[k]);
      ovf_s[k]     = i_en && i_valid[k] && hold_valid_r[k] && !drain_s[k];
    end
  end

  // Lane hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= {NUM_INPUT_DATA{1'b0}};
      for (int k = 0; k < NUM_INPUT_DATA; k++) begin
        hold_data_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_INPUT_DATA; k++) begin
        if (capture_s[k]) begin
          hold_valid_r[k] <= 1'b1;
          hold_data_r[k]  <= i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (drain_s[k]) begin
          hold_valid_r[k] <= 1'b0;
        end else begin
          hold_valid_r[k] <= hold_valid_r[k];
        end
      end
    end
  end

  // Sticky drop flags; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow <= {NUM_INPUT_DATA{1'b0}};
    end else if (i_clear_overflow) begin
      o_overflow <= ovf_s;
    end else begin
      o_overflow <= o_overflow | ovf_s;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= {(DATA_WIDTH*NUM_OUTPUT_DATA){1'b0}};
      o_src_id   <= {IDX_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
    end else if (load_s) begin
      if (grant_found_s) begin
        o_valid    <= 1'b1;
        o_data_bus <= hold_data_r[grant_idx_s];
        o_src_id   <= grant_idx_s;
        rr_ptr_r   <= grant_idx_s + IDX_W'(1);
      end else begin
        o_valid    <= 1'b0;
      end
    end else begin
      o_valid    <= o_valid;
    end
  end

endmodule

// File: tb/tb_xbar_output_merge_8_1_seq.sv
// Randomized and directed bench for xbar_output_merge_8_1_seq against a
// transaction-level reference model of the lane merge rules.
module tb_xbar_output_merge_8_1_seq;

  logic         clk;
  logic         rst;
  logic [7:0]   i_valid;
  logic [255:0] i_data_bus;
  logic         i_en;
  logic         i_ready;
  logic         i_clear_overflow;
  logic         o_valid;
  logic [31:0]  o_data_bus;
  logic [2:0]   o_src_id;
  logic [7:0]   o_overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_hv;
  logic [31:0] m_hd [8];
  int          m_ptr;
  logic        m_ov;
  logic [31:0] m_od;
  logic [2:0]  m_id;
  logic [7:0]  m_ovf;

  xbar_output_merge_8_1_seq dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_en(i_en), .i_ready(i_ready), .i_clear_overflow(i_clear_overflow),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_src_id(o_src_id),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    m_hv = 8'h00; m_ptr = 0; m_ov = 1'b0; m_od = 32'h0; m_id = 3'd0; m_ovf = 8'h00;
    for (int k = 0; k < 8; k++) m_hd[k] = 32'h0;
  endtask

  task automatic mdl_step();
    bit          loadable, found, dr;
    int          g, j;
    logic [7:0]  nhv, novf;
    logic [31:0] nhd [8];
    loadable = !m_ov || i_ready;
    found = 1'b0; g = 0;
    if (loadable)
      for (int i = 0; i < 8; i++) begin
        j = (m_ptr + i) % 8;
        if (!found && m_hv[j]) begin found = 1'b1; g = j; end
      end
    nhv = m_hv; nhd = m_hd; novf = 8'h00;
    for (int k = 0; k < 8; k++) begin
      dr = found && (g == k);
      if (dr) nhv[k] = 1'b0;
      if (i_en && i_valid[k]) begin
        if (!m_hv[k] || dr) begin nhv[k] = 1'b1; nhd[k] = i_data_bus[k*32 +: 32]; end
        else novf[k] = 1'b1;
      end
    end
    m_ovf = (i_clear_overflow ? 8'h00 : m_ovf) | novf;
    if (loadable) begin
      if (found) begin m_ov = 1'b1; m_od = m_hd[g]; m_id = 3'(g); m_ptr = (g + 1) % 8; end
      else m_ov = 1'b0;
    end
    m_hv = nhv; m_hd = nhd;
  endtask

  // One clock: model follows the edge, bench returns on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) mdl_reset(); else mdl_step();
    @(negedge clk);
  endtask

  task automatic set_lane(input int k, input logic [31:0] d);
    i_data_bus[k*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== 44'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, 44'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {m_ov, m_od, m_id, m_ovf}) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, {m_ov, m_od, m_id, m_ovf});
    end
  endtask

  task automatic test_single();
    i_ready = 1'b1; i_en = 1'b1; i_valid = 8'h04; set_lane(2, 32'hA5A5_0002);
    tick();
    i_valid = 8'h00;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL single_e0: got o_valid=%b expected 0", o_valid); end
    tick();
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {1'b1, 32'hA5A5_0002, 3'd2, 8'h00}) begin
      errors++;
      $display("FAIL single_e1: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, {1'b1, 32'hA5A5_0002, 3'd2, 8'h00});
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL single_e2: got o_valid=%b expected 0", o_valid); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    i_valid = 8'hFF;
    for (int k = 0; k < 8; k++) set_lane(k, 32'(k + 1));
    tick();
    i_valid = 8'h00;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if ({o_valid, o_data_bus, o_src_id} !== {1'b1, 32'(j + 1), 3'(j)}) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %h expected %h", j, {o_valid, o_data_bus, o_src_id}, {1'b1, 32'(j + 1), 3'(j)});
      end
    end
    tick();
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {m_ov, m_od, m_id, m_ovf}) begin
      errors++;
      $display("FAIL rr_tail: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, {m_ov, m_od, m_id, m_ovf});
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_id [3];
    exp_id[0] = 3'd5; exp_id[1] = 3'd1; exp_id[2] = 3'd5;
    i_valid = 8'h20; set_lane(5, 32'h0000_0055);
    tick();
    i_valid = 8'h00;
    tick();
    checks++;
    if ({o_valid, o_src_id} !== {1'b1, exp_id[0]}) begin
      errors++; $display("FAIL rot_setup: got v=%b id=%0d expected v=1 id=5", o_valid, o_src_id);
    end
    i_valid = 8'h22; set_lane(1, 32'h0000_0011); set_lane(5, 32'h0000_0056);
    tick();
    i_valid = 8'h00;
    for (int j = 1; j < 3; j++) begin
      tick();
      checks++;
      if ({o_valid, o_src_id} !== {1'b1, exp_id[j]} || o_data_bus !== m_od) begin
        errors++;
        $display("FAIL rot_order[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", j, o_valid, o_src_id, o_data_bus, exp_id[j], m_od);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen1, seen2;
    seen1 = 1'b0; seen2 = 1'b0;
    i_valid = 8'h01; set_lane(0, 32'hC0DE_0000);
    tick();
    i_valid = 8'h00;
    tick();
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = (c < 2) ? 8'h08 : 8'h00;
      set_lane(3, 32'(c + 1));
      i_clear_overflow = (c == 1);
      tick();
      checks++;
      if ({o_valid, o_data_bus, o_src_id} !== {1'b1, 32'hC0DE_0000, 3'd0}) begin
        errors++;
        $display("FAIL stall_stable[%0d]: got %h expected %h", c, {o_valid, o_data_bus, o_src_id}, {1'b1, 32'hC0DE_0000, 3'd0});
      end
      if (c >= 1) begin
        checks++;
        if (o_overflow[3] !== 1'b1) begin errors++; $display("FAIL stall_ovf[%0d]: got %b expected 1", c, o_overflow[3]); end
      end
    end
    i_valid = 8'h00; i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    checks++;
    if (o_overflow !== 8'h00) begin errors++; $display("FAIL ovf_clear: got %h expected 00", o_overflow); end
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_valid && o_src_id == 3'd3 && o_data_bus == 32'h1) seen1 = 1'b1;
      if (o_valid && o_src_id == 3'd3 && o_data_bus == 32'h2) seen2 = 1'b1;
    end
    checks++;
    if (!seen1 || seen2) begin errors++; $display("FAIL stall_delivery: got seen1=%b seen2=%b expected 1 0", seen1, seen2); end
  endtask

  task automatic test_enable();
    logic [2:0]  exp_id [2];
    logic [31:0] exp_d [2];
    exp_id[0] = 3'd6; exp_id[1] = 3'd2; exp_d[0] = 32'h6666_0006; exp_d[1] = 32'h2222_0002;
    i_valid = 8'h44; set_lane(2, exp_d[1]); set_lane(6, exp_d[0]);
    tick();
    i_en = 1'b0; i_valid = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) set_lane(k, $urandom());
      tick();
      checks++;
      if (c < 2) begin
        if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {1'b1, exp_d[c], exp_id[c], 8'h00}) begin
          errors++;
          $display("FAIL en_drain[%0d]: got %h expected %h", c, {o_valid, o_data_bus, o_src_id, o_overflow}, {1'b1, exp_d[c], exp_id[c], 8'h00});
        end
      end else if ({o_valid, o_overflow} !== 9'h000) begin
        errors++;
        $display("FAIL en_gate[%0d]: got v=%b ovf=%h expected v=0 ovf=00", c, o_valid, o_overflow);
      end
    end
    i_en = 1'b1; i_valid = 8'h00;
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0; i_valid = 8'h5A;
    for (int k = 0; k < 8; k++) set_lane(k, 32'hF00D_0000 | 32'(k));
    tick(); tick();
    i_valid = 8'h00;
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {m_ov, m_od, m_id, m_ovf}) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, {m_ov, m_od, m_id, m_ovf});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_data_bus, o_src_id, o_overflow} !== 44'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", {o_valid, o_data_bus, o_src_id, o_overflow}, 44'h0);
    end
    mdl_reset();
    tick();
    rst = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0 || {o_valid, o_data_bus, o_src_id, o_overflow} !== {m_ov, m_od, m_id, m_ovf}) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %h expected %h", c, {o_valid, o_data_bus, o_src_id, o_overflow}, {m_ov, m_od, m_id, m_ovf});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_en = ($urandom_range(0, 9) != 0);
      i_valid = 8'($urandom());
      i_ready = ($urandom_range(0, 9) < 7);
      i_clear_overflow = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 8; k++) set_lane(k, $urandom());
      tick();
      checks++;
      if ({o_valid, o_data_bus, o_src_id, o_overflow} !== {m_ov, m_od, m_id, m_ovf}) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", c, {o_valid, o_data_bus, o_src_id, o_overflow}, {m_ov, m_od, m_id, m_ovf});
      end
    end
    i_valid = 8'h00; i_clear_overflow = 1'b0; i_en = 1'b1; i_ready = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    i_valid = 8'h00; i_data_bus = 256'h0; i_en = 1'b1; i_ready = 1'b1; i_clear_overflow = 1'b0;
    mdl_reset();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
